// File: rtl/ch0re_pkg.sv
// ---------------------------------------------------------------------------
// ch0re_pkg
// Shared types and constants for the ch0re in-flight write tracker.
//   hz_entry_t : one tracked pipeline slot {valid, rd, is_load}
//   REG_ZERO   : architectural x0, never produces a hazard
//   HZ_BUBBLE  : empty slot value (what a stall or flush inserts)
// ---------------------------------------------------------------------------
package ch0re_pkg;

    localparam int        REG_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, rd: REG_ZERO, is_load: 1'b0};

endpackage

// File: rtl/ch0re_hazard_match.sv
// ---------------------------------------------------------------------------
// ch0re_hazard_match
// Priority finder for one decode read port. Scans the tracked slots and
// reports the youngest (lowest index) slot whose destination matches the
// source register, whether that slot's result is already usable, and which
// slot it is.
// Ports:
//   i_slots  : tracked entries, slot 0 = EX ... slot DEPTH-1 = WB
//   i_raddr  : decode source register for this port
//   o_hit    : some slot matches (x0 never matches)
//   o_ready  : the youngest matching slot holds a usable result
//   o_slot   : index of the youngest matching slot (0 when no hit)
// ---------------------------------------------------------------------------
module ch0re_hazard_match
    import ch0re_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int IDX_W      = 2
) (
    input  hz_entry_t [DEPTH-1:0] i_slots,
    input  logic [4:0]            i_raddr,
    output logic                  o_hit,
    output logic                  o_ready,
    output logic [IDX_W-1:0]      o_slot
);

    // Walk from oldest to youngest so the youngest match is the last writer.
    always_comb begin
        o_hit   = 1'b0;
        o_ready = 1'b0;
        o_slot  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_slots[k].valid && (i_slots[k].rd == i_raddr) && (i_raddr != REG_ZERO)) begin
                o_hit   = 1'b1;
                // A load result only exists once the entry reaches LOAD_STAGE.
                o_ready = !i_slots[k].is_load || (k >= LOAD_STAGE);
                o_slot  = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/ch0re_hazard_track.sv
// ---------------------------------------------------------------------------
// ch0re_hazard_track
// In-flight register-write tracker beside the ID stage of the ch0re RV64I
// pipeline. Follows every issued register write through DEPTH post-decode
// slots (EX..WB) and, for each decode read port, either forwards the value
// from the youngest producing slot or requests a decode stall.
//
// Build option: CH0RE_FWD_EN
//   defined   : forwarding from any slot whose result is ready
//   undefined : interlock only; any match stalls until the entry retires,
//               o_fwd_hit / o_fwd_data stay 0
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_stall         : external freeze, all slots hold (flush still clears slot 0)
//   i_flush         : kill the instruction entering slot 0
//   i_issue_valid   : decode presents an instruction this cycle
//   i_issue_rd/wen/load : its destination, write enable and load flag
//   i_stage_wdata   : per-slot result values, slot k at [k*XLEN +: XLEN]
//   i_raddr         : decode source registers, port p at [p*5 +: 5]
//   o_fwd_hit       : port p must take o_fwd_data[p] instead of the regfile
//   o_fwd_data      : forwarded values, port p at [p*XLEN +: XLEN]
//   o_stall_req     : decode must hold; a bubble enters slot 0
//   o_stall_cnt     : saturating count of advancing cycles with o_stall_req=1
//
// Issue handshake: i_issue_valid is the decode's offer. The instruction is
// accepted into slot 0 only on a posedge with i_stall=0, o_stall_req=0 and
// i_flush=0; otherwise decode keeps presenting it and slot 0 takes a bubble.
// ---------------------------------------------------------------------------
module ch0re_hazard_track
    import ch0re_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 3,
    parameter int NUM_RPORTS = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_issue_valid,
    input  logic [4:0]                 i_issue_rd,
    input  logic                       i_issue_wen,
    input  logic                       i_issue_load,
    input  logic [DEPTH*XLEN-1:0]      i_stage_wdata,
    input  logic [NUM_RPORTS*5-1:0]    i_raddr,
    output logic [NUM_RPORTS-1:0]      o_fwd_hit,
    output logic [NUM_RPORTS*XLEN-1:0] o_fwd_data,
    output logic                       o_stall_req,
    output logic [CNT_WIDTH-1:0]       o_stall_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    hz_entry_t [DEPTH-1:0]  r_slots;
    hz_entry_t              w_issue_entry;
    logic [NUM_RPORTS-1:0]  w_hit;
    logic [NUM_RPORTS-1:0]  w_ready;
    logic [NUM_RPORTS-1:0]  w_port_stall;
    logic [IDX_W-1:0]       w_slot [NUM_RPORTS];
    logic                   w_stall_req;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;

    // Writes to x0 or without wen are architecturally invisible: track as empty.
    always_comb begin
        w_issue_entry.valid   = i_issue_valid && i_issue_wen && (i_issue_rd != REG_ZERO);
        w_issue_entry.rd      = i_issue_rd;
        w_issue_entry.is_load = i_issue_load;
    end

    // Slot shift register. Under i_stall everything freezes except that a
    // flush still empties slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
        end else if (!i_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
            r_slots[0] <= (w_stall_req || i_flush) ? HZ_BUBBLE : w_issue_entry;
        end else if (i_flush) begin
            r_slots[0] <= HZ_BUBBLE;
        end
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_match
        ch0re_hazard_match #(
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .IDX_W      (IDX_W)
        ) u_match (
            .i_slots (r_slots),
            .i_raddr (i_raddr[p*5 +: 5]),
            .o_hit   (w_hit[p]),
            .o_ready (w_ready[p]),
            .o_slot  (w_slot[p])
        );
    end

`ifdef CH0RE_FWD_EN
    logic [XLEN-1:0] w_stage_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign w_stage_data[k] = i_stage_wdata[k*XLEN +: XLEN];
    end

    // Only the youngest match matters: if it is a load not yet at LOAD_STAGE,
    // an older ready producer of the same register would be stale data.
    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_fwd
        assign w_port_stall[p]          = w_hit[p] & ~w_ready[p];
        assign o_fwd_hit[p]             = w_hit[p] &  w_ready[p];
        assign o_fwd_data[p*XLEN +: XLEN] = (w_hit[p] && w_ready[p]) ? w_stage_data[w_slot[p]] : '0;
    end
`else
    // Interlock only: the register file is not write-through, so any
    // in-flight producer (WB included) blocks the read until it retires.
    logic [NUM_RPORTS-1:0] w_unused_port;
    logic                  w_unused;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_ilk
        assign w_port_stall[p]  = w_hit[p];
        assign w_unused_port[p] = w_ready[p] ^ (^w_slot[p]);
    end

    assign w_unused   = ^{i_stage_wdata, w_unused_port};
    assign o_fwd_hit  = '0;
    assign o_fwd_data = '0;
`endif

    assign w_stall_req = i_issue_valid & (|w_port_stall);
    assign o_stall_req = w_stall_req;

    // Counts only cycles where the stall actually costs a decode slot, i.e.
    // the pipe is advancing; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_req && !i_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ch0re_hazard_track.sv
// ---------------------------------------------------------------------------
// tb_ch0re_hazard_track
// Directed, table-driven bench for ch0re_hazard_track (DEPTH=3, LOAD_STAGE=1,
// 2 read ports, 4-bit stall counter so saturation is reachable). Expectations
// for both builds (CH0RE_FWD_EN defined or not) are hand-computed per vector.
// Readers never write and writers only read x0, so the slot contents evolve
// identically in both builds even though stalls differ.
// ---------------------------------------------------------------------------
module tb_ch0re_hazard_track;

    localparam int XLEN = 64;
    localparam int DEPTH = 3;
    localparam int NP = 2;
    localparam int CW = 4;

`ifdef CH0RE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [63:0] WA = 64'hA;   // slot 0 (EX) value
    localparam logic [63:0] WC = 64'hC;   // slot 1 (MEM) value
    localparam logic [63:0] WB = 64'hB;   // slot 2 (WB) value

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                 i_stall, i_flush, i_issue_valid, i_issue_wen, i_issue_load;
    logic [4:0]           i_issue_rd;
    logic [DEPTH*XLEN-1:0] i_stage_wdata;
    logic [NP*5-1:0]      i_raddr;
    logic [NP-1:0]        o_fwd_hit;
    logic [NP*XLEN-1:0]   o_fwd_data;
    logic                 o_stall_req;
    logic [CW-1:0]        o_stall_cnt;

    assign i_stage_wdata = {WB, WC, WA};

    ch0re_hazard_track #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RPORTS(NP), .LOAD_STAGE(1), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_issue_wen   (i_issue_wen),
        .i_issue_load  (i_issue_load),
        .i_stage_wdata (i_stage_wdata),
        .i_raddr       (i_raddr),
        .o_fwd_hit     (o_fwd_hit),
        .o_fwd_data    (o_fwd_data),
        .o_stall_req   (o_stall_req),
        .o_stall_cnt   (o_stall_cnt)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] exp_cnt  = '0;
    logic [CW-1:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic fl, input logic st);
        i_issue_valid = iv;
        i_issue_rd    = rd;
        i_issue_wen   = wen;
        i_issue_load  = ld;
        i_raddr       = {ra1, ra0};
        i_flush       = fl;
        i_stall       = st;
    endtask

    // Called 1 time unit after a posedge with inputs already driven. Compares
    // mid-cycle, clocks once, and advances the counter model.
    task automatic step_check(input string nm, input logic [1:0] eh,
                              input logic [63:0] ed0, input logic [63:0] ed1,
                              input logic esf, input logic esi);
        logic [1:0]  h;
        logic [63:0] a0, a1;
        logic        s;
        logic [CW-1:0] c;
        #2;
        if (FWD) begin
            h = eh; a0 = ed0; a1 = ed1; s = esf;
        end else begin
            h = 2'b00; a0 = '0; a1 = '0; s = esi;
        end
        c = exp_q.pop_front();
        check({nm, ".hit"},   64'(o_fwd_hit), 64'(h));
        check({nm, ".d0"},    o_fwd_data[63:0], a0);
        check({nm, ".d1"},    o_fwd_data[127:64], a1);
        check({nm, ".stall"}, 64'(o_stall_req), 64'(s));
        check({nm, ".cnt"},   64'(o_stall_cnt), 64'(c));
        @(posedge clk);
        if (s && !i_stall && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
        exp_q.push_back(exp_cnt);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  hit;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        sf;    // stall expected with forwarding
        logic        si;    // stall expected interlock-only
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic wen, input logic ld,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] hit,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic sf, input logic si);
        mk = '{iv: iv, rd: rd, wen: wen, ld: ld, ra0: ra0, ra1: ra1,
               hit: hit, d0: d0, d1: d1, sf: sf, si: si};
    endfunction

    vec_t vecs [22];

    initial begin
        //            iv rd wen ld ra0 ra1 hit    d0  d1  sf si
        vecs[0]  = mk(0, 0, 0, 0,  5,  6, 2'b00, 0,  0,  0, 0);  // reset state
        vecs[1]  = mk(1, 5, 1, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // addi x5
        vecs[2]  = mk(1, 0, 0, 0,  5,  0, 2'b01, WA, 0,  0, 1);  // x5 in EX
        vecs[3]  = mk(1, 0, 0, 0,  0,  5, 2'b10, 0,  WC, 0, 1);  // x5 in MEM
        vecs[4]  = mk(1, 0, 0, 0,  0,  5, 2'b10, 0,  WB, 0, 1);  // x5 in WB
        vecs[5]  = mk(1, 0, 0, 0,  0,  5, 2'b00, 0,  0,  0, 0);  // x5 retired
        vecs[6]  = mk(1, 0, 1, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // write x0
        vecs[7]  = mk(1, 0, 0, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // read x0
        vecs[8]  = mk(1, 6, 1, 1,  0,  0, 2'b00, 0,  0,  0, 0);  // ld x6
        vecs[9]  = mk(1, 0, 0, 0,  6,  0, 2'b00, 0,  0,  1, 1);  // load-use stall
        vecs[10] = mk(1, 0, 0, 0,  6,  0, 2'b01, WC, 0,  0, 1);  // load fwd from MEM
        vecs[11] = mk(0, 0, 0, 0,  6,  0, 2'b01, WB, 0,  0, 0);  // no issue: stall gated
        vecs[12] = mk(1, 7, 1, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // addi x7
        vecs[13] = mk(0, 0, 0, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // gap
        vecs[14] = mk(1, 7, 1, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // addi x7 again
        vecs[15] = mk(1, 0, 0, 0,  7,  7, 2'b11, WA, WA, 0, 1);  // youngest (slot0) wins
        vecs[16] = mk(1, 8, 1, 1,  0,  0, 2'b00, 0,  0,  0, 0);  // ld x8
        vecs[17] = mk(1, 0, 0, 0,  8,  7, 2'b10, 0,  WB, 1, 1);  // port0 load stall, port1 WB fwd
        vecs[18] = mk(1, 9, 1, 0,  0,  0, 2'b00, 0,  0,  0, 0);  // addi x9
        vecs[19] = mk(1, 9, 1, 1,  0,  0, 2'b00, 0,  0,  0, 0);  // ld x9 over it
        vecs[20] = mk(1, 0, 0, 0,  9,  9, 2'b00, 0,  0,  1, 1);  // young load hides older ready
        vecs[21] = mk(1, 0, 0, 0,  9,  0, 2'b01, WC, 0,  0, 1);  // load now in MEM
    end

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back('0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].iv, vecs[i].rd, vecs[i].wen, vecs[i].ld, vecs[i].ra0, vecs[i].ra1, 0, 0);
            step_check($sformatf("vec%0d", i), vecs[i].hit, vecs[i].d0, vecs[i].d1,
                       vecs[i].sf, vecs[i].si);
        end

        // Flush kills a load as it enters slot 0.
        drive(1, 8, 1, 1, 0, 0, 1, 0); step_check("flush_ld",  2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 8, 0, 0, 0); step_check("flush_rd",  2'b00, 0, 0, 0, 0);

        // Stall + flush: slot 0 cleared, slot 1 holds.
        drive(1, 6, 1, 0, 0, 0, 0, 0); step_check("sf_w6",     2'b00, 0, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0); step_check("sf_w5",     2'b00, 0, 0, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 1, 1); step_check("sf_both",   2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 5, 6, 0, 1); step_check("sf_frozen", 2'b10, 0, WC, 0, 1);
        drive(1, 0, 0, 0, 5, 6, 0, 0); step_check("sf_held",   2'b10, 0, WC, 0, 1);
        drive(1, 0, 0, 0, 0, 6, 0, 0); step_check("sf_wb",     2'b10, 0, WB, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step_check("sf_drain",  2'b00, 0, 0, 0, 0);

        // Repeated load-use chains drive the 4-bit counter into saturation.
        for (int i = 0; i < 14; i++) begin
            drive(1, 10, 1, 1, 0, 0, 0, 0);  step_check("sat_ld",  2'b00, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 10, 0, 0, 0);  step_check("sat_ex",  2'b00, 0, 0, 1, 1);
            drive(1, 0, 0, 0, 10, 0, 0, 0);  step_check("sat_mem", 2'b01, WC, 0, 0, 1);
            drive(1, 0, 0, 0, 10, 0, 0, 0);  step_check("sat_wb",  2'b01, WB, 0, 0, 1);
        end
        check("sat_cnt", 64'(o_stall_cnt), 64'hF);

        // Reset asserted while a stall is pending clears everything at once.
        drive(1, 11, 1, 1, 0, 0, 0, 0);  step_check("rst_ld", 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 11, 0, 0, 0);
        #2;
        check("pre_rst.stall", 64'(o_stall_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst.stall", 64'(o_stall_req), 64'd0);
        check("rst.cnt",   64'(o_stall_cnt), 64'd0);
        check("rst.hit",   64'(o_fwd_hit),   64'd0);
        check("rst.data",  o_fwd_data[63:0], 64'd0);
        exp_cnt = '0;
        exp_q.delete();
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 11, 0, 0, 0); step_check("post_rst", 2'b00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
